if_stage: RTL

- Instruction-fetch stage, directly upstream of ID.
- Holds the PC and issues one outstanding request at a time to the instruction memory.
- Captures the returned instruction into a single-entry IF/ID buffer with a valid/ready handshake toward ID.
- Applies branch redirects from EX, discarding stale in-flight fetches.

---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_pc_reg.sv | 43 ++++
 rtl/if_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding,
// next-PC select codes and the PC increment.
package if_stage_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_WAIT  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  // Next-PC selection for the PC register
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC4  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  // Fixed instruction stride in bytes
  localparam int PC_INC = 4;

endpackage

// File: rtl/if_stage_pc_reg.sv
// PC register with hold / +4 / redirect next-PC mux. Redirect targets are
// forced word-aligned. Also exports pc + 4 so the fetch stage can reuse it.
module if_stage_pc_reg
  import if_stage_pkg::*;
#(
  parameter int              WORD     = 64,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel,
  input  logic [WORD-1:0] target,
  output logic [WORD-1:0] pc,
  output logic [WORD-1:0] pc_plus4
);

  logic [WORD-1:0] pc_reg;
  logic [WORD-1:0] pc_next;

  // Sequential increment wraps naturally modulo 2^WORD
  assign pc_plus4 = pc_reg + WORD'(PC_INC);
  assign pc       = pc_reg;

  // Select the next PC; redirect clears the two low address bits
  always_comb begin
    pc_next = pc_reg;
    case (sel)
      PC_INC4:  pc_next = pc_plus4;
      PC_REDIR: pc_next = {target[WORD-1:2], 2'b00};
      default:  pc_next = pc_reg;
    endcase
  end

  // PC state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, a
// single-entry IF/ID buffer with valid/ready toward ID, and branch redirect
// that discards any fetch already in flight.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              WORD      = 64,
  parameter int              INST_SIZE = 32,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_taken,
  input  logic [WORD-1:0]      br_target,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_rvalid,
  input  logic [INST_SIZE-1:0] imem_rdata,
  input  logic                 id_ready,
  output logic                 if_valid,
  output logic [INST_SIZE-1:0] if_inst,
  output logic [WORD-1:0]      if_pc,
  output logic [WORD-1:0]      if_pc_plus4
);

  if_state_e            state_reg;
  if_state_e            state_next;
  pc_sel_e              pc_sel;
  logic [WORD-1:0]      pc;
  logic [WORD-1:0]      pc_plus4;
  logic                 slot_free;
  logic                 capture;
  logic                 if_valid_reg;
  logic                 if_valid_next;
  logic [INST_SIZE-1:0] if_inst_reg;
  logic [WORD-1:0]      if_pc_reg;
  logic [WORD-1:0]      if_pc_plus4_reg;

  if_stage_pc_reg #(
    .WORD     (WORD),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .sel      (pc_sel),
    .target   (br_target),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // Next-state, request and PC-select decode; redirect beats everything else
  always_comb begin
    state_next = state_reg;
    pc_sel     = PC_HOLD;
    imem_req   = 1'b0;
    capture    = 1'b0;
    slot_free  = !if_valid_reg || id_ready;
    case (state_reg)
      IF_FETCH: begin
        if (br_taken) begin
          pc_sel = PC_REDIR;
        end else if (slot_free && !rst) begin
          // rst gating keeps the request low while reset is held
          imem_req   = 1'b1;
          state_next = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (br_taken) begin
          pc_sel     = PC_REDIR;
          state_next = imem_rvalid ? IF_FETCH : IF_DROP;
        end else if (imem_rvalid) begin
          capture    = 1'b1;
          pc_sel     = PC_INC4;
          state_next = IF_FETCH;
        end
      end
      IF_DROP: begin
        if (br_taken) begin
          pc_sel = PC_REDIR;
        end
        if (imem_rvalid) begin
          state_next = IF_FETCH;
        end
      end
      default: state_next = IF_FETCH;
    endcase
  end

  // Address bus is driven only alongside a request
  assign imem_addr = imem_req ? pc : '0;

  // Buffer valid: flush on redirect, set on capture, clear on consume
  always_comb begin
    if_valid_next = if_valid_reg;
    if (br_taken) begin
      if_valid_next = 1'b0;
    end else if (capture) begin
      if_valid_next = 1'b1;
    end else if (if_valid_reg && id_ready) begin
      if_valid_next = 1'b0;
    end
  end

  // FSM state and buffer-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IF_FETCH;
      if_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_valid_reg <= if_valid_next;
    end
  end

  // Buffer payload only changes on capture, so it holds while ID stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_inst_reg     <= '0;
      if_pc_reg       <= '0;
      if_pc_plus4_reg <= '0;
    end else if (capture) begin
      if_inst_reg     <= imem_rdata;
      if_pc_reg       <= pc;
      if_pc_plus4_reg <= pc_plus4;
    end
  end

  assign if_valid    = if_valid_reg;
  assign if_inst     = if_inst_reg;
  assign if_pc       = if_pc_reg;
  assign if_pc_plus4 = if_pc_plus4_reg;

  // A request is only issued once the slot frees, so a response never
  // lands on an occupied buffer
  assert property (@(posedge clk) disable iff (rst)
    (state_reg == IF_WAIT && imem_rvalid) |-> !if_valid_reg);

endmodule
